ppu_vram_arb: RTL

- Arbitrates single-port PPU VRAM (ppumc, one access per clock, 1-cycle synchronous read) between two requesters.
- Requesters are the rendering fetch engine (reads only) and the CPU PPUDATA ($2007) port (reads and writes).
- Rendering has fixed priority. CPU accesses are buffered one deep and issued in idle slots.
- Sits between the PPU core and ppumc. Drives ppumc addr/wr/din and receives its dout.

---
 rtl/ppu_vram_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ppu_vram_arb.sv
// ppu_vram_arb: fixed-priority render/CPU arbiter for single-port PPU VRAM.
// Build option PPU_ARB_STARVE_GUARD_EN forces long-starved CPU accesses.
module ppu_vram_arb #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren_req,
  input  logic [13:0] ren_addr,
  output logic        ren_stall,
  output logic        ren_rd_valid,
  output logic [7:0]  ren_rd_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_busy,
  output logic        cpu_rd_valid,
  output logic [7:0]  cpu_rd_data,
  output logic [13:0] mem_addr,
  output logic        mem_wr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  if (WAIT_W < $clog2(MAX_WAIT + 1)) begin : g_wait_w_chk
    $error("WAIT_W cannot hold MAX_WAIT");
  end

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  data;
  } cpu_acc_t;

  state_t   state;
  state_t   state_nx;
  cpu_acc_t pend;

  logic       capture;
  logic       cpu_issue;
  logic       ren_issue;
  logic       force_cpu;
  logic       ren_s1;
  logic       ren_s2;
  logic       cpu_s1;
  logic       cpu_s2;
  logic [7:0] cpu_hold;

`ifdef PPU_ARB_STARVE_GUARD_EN
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (capture || cpu_issue) begin
      wait_cnt <= '0;
    end else if (state == S_PEND && wait_cnt != WAIT_LIM) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_cpu = (state == S_PEND) && (wait_cnt == WAIT_LIM);
`else
  assign force_cpu = 1'b0;
`endif

  assign ren_issue = ren_req & ~force_cpu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    cpu_issue = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpu_req) begin
          capture  = 1'b1;
          state_nx = S_PEND;
        end
      end
      S_PEND: begin
        if (!ren_req || force_cpu) begin
          cpu_issue = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (capture) begin
      pend <= '{wr: cpu_wr, addr: cpu_addr, data: cpu_wr_data};
    end
  end

  // Idle slots keep mem_addr; mem_din only changes on CPU writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_wr   <= 1'b0;
      mem_din  <= '0;
    end else begin
      mem_wr <= cpu_issue & pend.wr;
      unique case (1'b1)
        cpu_issue: begin
          mem_addr <= pend.addr;
          if (pend.wr) begin
            mem_din <= pend.data;
          end
        end
        ren_issue: mem_addr <= ren_addr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_s1 <= 1'b0;
      ren_s2 <= 1'b0;
      cpu_s1 <= 1'b0;
      cpu_s2 <= 1'b0;
    end else begin
      ren_s1 <= ren_issue;
      ren_s2 <= ren_s1;
      cpu_s1 <= cpu_issue & ~pend.wr;
      cpu_s2 <= cpu_s1;
    end
  end

  // Read data arrives in the valid cycle; keep a copy for later cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_hold <= '0;
    end else if (cpu_s2) begin
      cpu_hold <= mem_dout;
    end
  end

  assign cpu_busy     = (state == S_PEND);
  assign ren_stall    = force_cpu;
  assign ren_rd_valid = ren_s2;
  assign ren_rd_data  = ren_s2 ? mem_dout : 8'h00;
  assign cpu_rd_valid = cpu_s2;
  assign cpu_rd_data  = cpu_s2 ? mem_dout : cpu_hold;

endmodule
